// File: rtl/demux13.sv
// rtl/demux13.sv - 1:3 valid/ready demux with one register per output channel
// Define DEMUX13_ERR_DETECT_EN to build in the sticky invalid-select err flag.
module demux13 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       in_sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out1,
    output logic [WIDTH-1:0] out2,
    output logic [WIDTH-1:0] out3,
    output logic [2:0]       out_valid,
    input  logic [2:0]       out_ready,
    output logic             err,
    input  logic             err_clr
);

    logic [WIDTH-1:0] data_q [3];
    logic [2:0]       valid_q;
    logic [2:0]       load;
    logic [2:0]       drain;
    logic             accept;

    // A full channel can still accept when its consumer drains in the same cycle.
    always_comb begin
        in_ready = 1'b1;
        case (in_sel)
            2'd0:    in_ready = ~valid_q[0] | out_ready[0];
            2'd1:    in_ready = ~valid_q[1] | out_ready[1];
            2'd2:    in_ready = ~valid_q[2] | out_ready[2];
            default: in_ready = 1'b1;
        endcase
    end

    assign accept = in_valid & in_ready;

    always_comb begin
        load = 3'b000;
        if (accept) begin
            case (in_sel)
                2'd0:    load[0] = 1'b1;
                2'd1:    load[1] = 1'b1;
                2'd2:    load[2] = 1'b1;
                default: load    = 3'b000;
            endcase
        end
    end

    assign drain = valid_q & out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 3'b000;
            for (int k = 0; k < 3; k++) begin
                data_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < 3; k++) begin
                if (load[k]) begin
                    data_q[k]  <= in_data;
                    valid_q[k] <= 1'b1;
                end else if (drain[k]) begin
                    valid_q[k] <= 1'b0;
                end
            end
        end
    end

    assign out1      = data_q[0];
    assign out2      = data_q[1];
    assign out3      = data_q[2];
    assign out_valid = valid_q;

`ifdef DEMUX13_ERR_DETECT_EN
    logic err_q;

    // A new invalid-select beat outranks a coincident clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (accept && (in_sel == 2'd3)) begin
            err_q <= 1'b1;
        end else if (err_clr) begin
            err_q <= 1'b0;
        end
    end

    assign err = err_q;
`else
    logic unused_err_clr;

    assign unused_err_clr = err_clr;
    assign err            = 1'b0;
`endif

endmodule

// File: doc/demux13.md
DEMUX13 -- requirements
Module: demux13

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data width of every data port.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port in_data  input  WIDTH  data beat to be routed.
REQ-005 SHALL have port in_sel  input  2  destination select: 0->out1, 1->out2, 2->out3, 3->invalid.
REQ-006 SHALL have port in_valid  input  1  in_data/in_sel valid this cycle.
REQ-007 SHALL have port in_ready  output  1  block accepts the beat this cycle.
REQ-008 SHALL have ports out1, out2, out3  output  WIDTH each  registered channel data.
REQ-009 SHALL have port out_valid  output  3  bit k-1 set: outk holds a valid beat.
REQ-010 SHALL have port out_ready  input  3  bit k-1 set: consumer of outk takes the beat this cycle.
REQ-011 SHALL have port err  output  1  sticky invalid-select flag.
REQ-012 SHALL have port err_clr  input  1  clears err.

Function
REQ-013 SHALL hold one single-entry register per channel (data + valid bit); no other data storage.
REQ-014 SHALL define transfer in = in_valid & in_ready; transfer outk = out_valid[k-1] & out_ready[k-1].
REQ-015 SHALL drive in_ready combinationally: in_sel 0..2 -> (~out_valid[in_sel] | out_ready[in_sel]); in_sel 3 -> 1.
REQ-016 SHALL, on transfer in with in_sel=s (0..2), load in_data into channel s register and set out_valid[s] next cycle (latency 1 cycle).
REQ-017 SHALL, on transfer outk without a new load to channel k, clear out_valid[k-1] next cycle.
REQ-018 SHALL, on simultaneous transfer outk and load to channel k, keep out_valid[k-1]=1 and present the new beat next cycle (full-throughput, no bubble).
REQ-019 SHALL leave non-selected channels unaffected by an input transfer; each channel drains independently.
REQ-020 SHALL keep outk data stable while out_valid[k-1]=1 and out_ready[k-1]=0.
REQ-021 SHALL never deassert out_valid[k-1] without transfer outk (except reset).
REQ-022 SHALL, on transfer in with in_sel=3, discard the beat; no channel register changes.
REQ-023 SHALL ignore in_data/in_sel when in_valid=0.
REQ-024 SHALL ignore out_ready[k-1] while out_valid[k-1]=0.

Reset
REQ-025 SHALL, when rst=1 at a clock edge, clear out_valid to 3'b000, out1..out3 to 0, err to 0, regardless of in-flight handshakes.
REQ-026 SHALL discard any beat presented in the same cycle as rst=1; in_ready value during reset is don't-care but in_valid SHALL have no effect.
REQ-027 SHALL give rst priority over err_clr, loads and drains.

Configuration
REQ-028 SHALL use macro DEMUX13_ERR_DETECT_EN to compile the invalid-select error logic in or out.
REQ-029 SHALL, with DEMUX13_ERR_DETECT_EN defined: set err next cycle on transfer in with in_sel=3; hold it until err_clr=1 or rst; if set and clear coincide, set wins.
REQ-030 SHALL, without DEMUX13_ERR_DETECT_EN: tie err to 0, ignore err_clr; sel=3 beats still accepted and discarded per REQ-022.

Verification
REQ-031 SHALL cover: after rst, in_valid=1,in_sel=1,in_data=8'hA5, out_ready=3'b000 -> next cycle out_valid=3'b010, out2=8'hA5; then in_sel=1,in_data=8'h3C -> in_ready=0, out2 stays 8'hA5.
REQ-032 SHALL cover: channel 3 full with 8'h11, out_ready[2]=1 and in_valid=1,in_sel=2,in_data=8'h22 same cycle -> in_ready=1, next cycle out_valid[2]=1, out3=8'h22.
REQ-033 SHALL cover: back-to-back beats sel 0,1,2 with data 8'h01,8'h02,8'h03, out_ready=3'b111 -> each appears on out1/out2/out3 exactly one cycle after acceptance, in_ready=1 every cycle.
REQ-034 SHALL cover: in_valid=1,in_sel=3,in_data=8'hFF -> in_ready=1, out_valid unchanged; with DEMUX13_ERR_DETECT_EN err=1 next cycle, cleared one cycle after err_clr=1; without macro err stays 0.
REQ-035 SHALL cover: out1 and out3 full, rst=1 while in_valid=1,in_sel=1 -> next cycle out_valid=3'b000, all outputs 0, err=0.
REQ-036 SHALL cover: random in_valid/in_sel/out_ready for 10000 cycles against a scoreboard -> every accepted sel 0..2 beat delivered once, in order, per channel; none lost or duplicated.
